// File: rtl/store_buffer.sv
// Post-commit store buffer: queues CPU stores and drains them to the shared RAM port
// whenever no load is using it, flagging loads that overlap still-buffered stores.
module store_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [ADDRESS_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0]    st_data,
    input  logic [1:0]               st_type,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic [1:0]               ld_type,
    output logic                     ld_conflict,
    output logic                     mem_WE,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0]    mem_WD,
    output logic [1:0]               mem_dataType,
    output logic                     empty,
    output logic                     err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0]       ptr_t;
    typedef logic [PTR_W:0]         cnt_t;
    typedef logic [ADDRESS_WIDTH:0] ext_t;

    logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [1:0]               type_q [DEPTH];

    ptr_t head_q, tail_q;
    cnt_t count_q;
    logic err_q;

    logic push, bad_store, drain;
    logic [DEPTH-1:0] hit;
    ext_t ld_lo, ld_hi;

    function automatic logic [2:0] acc_size(input logic [1:0] t);
        case (t)
            2'b01:   acc_size = 3'd1;
            2'b10:   acc_size = 3'd2;
            default: acc_size = 3'd4;
        endcase
    endfunction

    assign st_ready  = (count_q != cnt_t'(DEPTH));
    assign empty     = (count_q == '0);
    assign err       = err_q;
    assign push      = st_valid && st_ready && (st_type != 2'b11);
    assign bad_store = st_valid && st_ready && (st_type == 2'b11);
    assign drain     = (count_q != '0) && !ld_valid;

    always_comb begin
        mem_WE       = 1'b0;
        mem_A        = '0;
        mem_WD       = '0;
        mem_dataType = 2'b00;
        if (drain) begin
            mem_WE       = 1'b1;
            mem_A        = addr_q[head_q];
            mem_WD       = data_q[head_q];
            mem_dataType = type_q[head_q];
        end
    end

    // Bounds carry one extra bit so a range ending past the top of memory never wraps to 0.
    assign ld_lo = {1'b0, ld_addr};
    assign ld_hi = ld_lo + ext_t'(acc_size(ld_type)) - ext_t'(1);

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        ptr_t offs;
        ext_t s_lo, s_hi;
        assign offs   = ptr_t'(g) - head_q;
        assign s_lo   = {1'b0, addr_q[g]};
        assign s_hi   = s_lo + ext_t'(acc_size(type_q[g])) - ext_t'(1);
        assign hit[g] = (cnt_t'(offs) < count_q) && (s_lo <= ld_hi) && (ld_lo <= s_hi);
    end

    assign ld_conflict = ld_valid && (|hit);

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            type_q[tail_q] <= st_type;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bad_store;
            if (push)  tail_q <= tail_q + ptr_t'(1);
            if (drain) head_q <= head_q + ptr_t'(1);
            unique case ({push, drain})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a per-cycle vector table plus scripted
// sequences for full-buffer back-pressure, push/drain overlap and mid-run reset.
module tb_store_buffer;

    logic        clk, rst;
    logic        st_valid, st_ready, ld_valid, ld_conflict;
    logic [31:0] st_addr, st_data, ld_addr;
    logic [1:0]  st_type, ld_type;
    logic        mem_WE, empty, err;
    logic [31:0] mem_A, mem_WD;
    logic [1:0]  mem_dataType;

    int n_checks = 0;
    int n_fail   = 0;

    store_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_type(ld_type), .ld_conflict(ld_conflict),
        .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_dataType(mem_dataType),
        .empty(empty), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [1:0]  st;
        logic        lv;
        logic [31:0] la;
        logic [1:0]  lt;
        logic        rdy;
        logic        conf;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  dt;
        logic        emp;
        logic        er;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(
        input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [1:0] st,
        input logic lv, input logic [31:0] la, input logic [1:0] lt,
        input logic rdy, input logic conf, input logic we, input logic [31:0] a,
        input logic [31:0] wd, input logic [1:0] dt, input logic emp, input logic er);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.st = st;
        v.lv = lv; v.la = la; v.lt = lt;
        v.rdy = rdy; v.conf = conf; v.we = we; v.a = a; v.wd = wd; v.dt = dt;
        v.emp = emp; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [1:0] st, input logic lv, input logic [31:0] la,
                         input logic [1:0] lt);
        st_valid = sv; st_addr = sa; st_data = sd; st_type = st;
        ld_valid = lv; ld_addr = la; ld_type = lt;
    endtask

    task automatic idle(input logic lv);
        drive(1'b0, 32'h0, 32'h0, 2'b00, lv, 32'h9000, 2'b00);
    endtask

    initial begin
        rst = 1'b0;
        idle(1'b0);
        #1 rst = 1'b1;
        #2;
        chk("rst.st_ready", 32'(st_ready), 32'd1);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.mem_WE", 32'(mem_WE), 32'd0);
        chk("rst.ld_conflict", 32'(ld_conflict), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //             sv  st_addr       st_data       st  lv  ld_addr       lt   rdy conf we mem_A        mem_WD        dt  emp err
        vecs[0]  = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[1]  = mk(1, 32'h1000,     32'hDEADBEEF, 0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[2]  = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 1, 32'h1000,     32'hDEADBEEF, 0, 0, 0);
        vecs[3]  = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[4]  = mk(1, 32'h1003,     32'hAB,       1, 1, 32'h2000,     0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[5]  = mk(0, 32'h0,        32'h0,        0, 1, 32'h1000,     0,   1, 1, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[6]  = mk(0, 32'h0,        32'h0,        0, 1, 32'h1004,     1,   1, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[7]  = mk(0, 32'h0,        32'h0,        0, 1, 32'h1002,     2,   1, 1, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[8]  = mk(1, 32'h1002,     32'h1234,     2, 1, 32'h0FFF,     0,   1, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[9]  = mk(0, 32'h0,        32'h0,        0, 1, 32'h0FFF,     0,   1, 1, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[10] = mk(0, 32'h0,        32'h0,        0, 1, 32'h1003,     1,   1, 1, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[11] = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 1, 32'h1003,     32'hAB,       1, 0, 0);
        vecs[12] = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 1, 32'h1002,     32'h1234,     2, 0, 0);
        vecs[13] = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[14] = mk(1, 32'h3000,     32'h5,        3, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[15] = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 1);
        vecs[16] = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[17] = mk(1, 32'h4000,     32'h11111111, 0, 1, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[18] = mk(1, 32'h4004,     32'h7,        3, 1, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[19] = mk(0, 32'h0,        32'h0,        0, 1, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 0, 1);
        vecs[20] = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 1, 32'h4000,     32'h11111111, 0, 0, 0);
        vecs[21] = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[22] = mk(1, 32'hFFFFFFFE, 32'h22,       0, 1, 32'h0,        1,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[23] = mk(0, 32'h0,        32'h0,        0, 1, 32'h0,        1,   1, 0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[24] = mk(0, 32'h0,        32'h0,        0, 1, 32'hFFFFFFFF, 1,   1, 1, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[25] = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 1, 32'hFFFFFFFE, 32'h22,       0, 0, 0);
        vecs[26] = mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        0,   1, 0, 0, 32'h0,        32'h0,        0, 1, 0);

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].st, vecs[i].lv, vecs[i].la, vecs[i].lt);
            #1;
            chk($sformatf("v%0d.st_ready", i), 32'(st_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d.ld_conflict", i), 32'(ld_conflict), 32'(vecs[i].conf));
            chk($sformatf("v%0d.mem_WE", i), 32'(mem_WE), 32'(vecs[i].we));
            chk($sformatf("v%0d.mem_A", i), mem_A, vecs[i].a);
            chk($sformatf("v%0d.mem_WD", i), mem_WD, vecs[i].wd);
            chk($sformatf("v%0d.mem_dataType", i), 32'(mem_dataType), 32'(vecs[i].dt));
            chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].emp));
            chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].er));
        end

        // Five back-to-back stores while a load holds the port: the fifth stalls.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h5000 + 32'(4 * k), 32'hA0 + 32'(k), 2'b00, 1'b1, 32'h9000, 2'b00);
            #1;
            chk($sformatf("full%0d.st_ready", k), 32'(st_ready), (k < 4) ? 32'd1 : 32'd0);
            chk($sformatf("full%0d.mem_WE", k), 32'(mem_WE), 32'd0);
        end
        @(negedge clk);
        drive(1'b1, 32'h5010, 32'hA4, 2'b00, 1'b0, 32'h9000, 2'b00);
        #1;
        chk("full.drain0.st_ready", 32'(st_ready), 32'd0);
        chk("full.drain0.mem_WE", 32'(mem_WE), 32'd1);
        chk("full.drain0.mem_A", mem_A, 32'h5000);
        chk("full.drain0.mem_WD", mem_WD, 32'hA0);
        @(negedge clk);
        #1;
        chk("full.drain1.st_ready", 32'(st_ready), 32'd1);
        chk("full.drain1.mem_A", mem_A, 32'h5004);
        chk("full.drain1.mem_WD", mem_WD, 32'hA1);
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            idle(1'b0);
            #1;
            chk($sformatf("full.drain%0d.mem_WE", k), 32'(mem_WE), 32'd1);
            chk($sformatf("full.drain%0d.mem_A", k), mem_A, 32'h5000 + 32'(4 * k));
            chk($sformatf("full.drain%0d.mem_WD", k), mem_WD, 32'hA0 + 32'(k));
        end
        @(negedge clk);
        idle(1'b0);
        #1;
        chk("full.end.mem_WE", 32'(mem_WE), 32'd0);
        chk("full.end.empty", 32'(empty), 32'd1);

        // Push and drain in the same cycle at count 2: two more pushes must exactly fill it.
        @(negedge clk);
        drive(1'b1, 32'h6000, 32'h1, 2'b00, 1'b1, 32'h9000, 2'b00);
        @(negedge clk);
        drive(1'b1, 32'h6004, 32'h2, 2'b00, 1'b1, 32'h9000, 2'b00);
        @(negedge clk);
        drive(1'b1, 32'h6008, 32'h3, 2'b00, 1'b0, 32'h9000, 2'b00);
        #1;
        chk("pd.both.mem_WE", 32'(mem_WE), 32'd1);
        chk("pd.both.mem_A", mem_A, 32'h6000);
        chk("pd.both.st_ready", 32'(st_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 32'h600C, 32'h4, 2'b00, 1'b1, 32'h9000, 2'b00);
        #1;
        chk("pd.c2.st_ready", 32'(st_ready), 32'd1);
        chk("pd.c2.ld_conflict", 32'(ld_conflict), 32'd0);
        @(negedge clk);
        drive(1'b1, 32'h6010, 32'h5, 2'b00, 1'b1, 32'h9000, 2'b00);
        #1;
        chk("pd.c3.st_ready", 32'(st_ready), 32'd1);
        @(negedge clk);
        idle(1'b1);
        #1;
        chk("pd.c4.st_ready", 32'(st_ready), 32'd0);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            idle(1'b0);
            #1;
            chk($sformatf("pd.drain%0d.mem_A", k), mem_A, 32'h6000 + 32'(4 * k));
            chk($sformatf("pd.drain%0d.mem_WD", k), mem_WD, 32'(k + 1));
        end
        @(negedge clk);
        #1;
        chk("pd.end.empty", 32'(empty), 32'd1);

        // Asynchronous reset in the middle of a drain cycle with three stores queued.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h7000 + 32'(4 * k), 32'h70 + 32'(k), 2'b00, 1'b1, 32'h9000, 2'b00);
        end
        @(negedge clk);
        idle(1'b0);
        #1;
        chk("ar.pre.mem_WE", 32'(mem_WE), 32'd1);
        chk("ar.pre.mem_A", mem_A, 32'h7000);
        #2 rst = 1'b1;
        #1;
        chk("ar.mid.mem_WE", 32'(mem_WE), 32'd0);
        chk("ar.mid.empty", 32'(empty), 32'd1);
        chk("ar.mid.st_ready", 32'(st_ready), 32'd1);
        chk("ar.mid.err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle(1'b0);
            #1;
            chk($sformatf("ar.post%0d.mem_WE", k), 32'(mem_WE), 32'd0);
            chk($sformatf("ar.post%0d.empty", k), 32'(empty), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
